// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect input, IF/ID handshake and status.
interface instruction_fetch_if #(
   parameter int address_length = 3
);
   logic [address_length-1:0] imem_address;
   logic [31:0]               imem_data;
   logic                      redirect_valid;
   logic [address_length-1:0] redirect_target;
   logic                      valid_out;
   logic                      ready_in;
   logic [31:0]               instr_out;
   logic [address_length-1:0] pc_out;
   logic [15:0]               fetch_count;
   logic                      halted;

   modport master (
      output imem_address,
      input  imem_data,
      input  redirect_valid,
      input  redirect_target,
      output valid_out,
      input  ready_in,
      output instr_out,
      output pc_out,
      output fetch_count,
      output halted
   );

   modport slave (
      input  imem_address,
      output imem_data,
      output redirect_valid,
      output redirect_target,
      input  valid_out,
      output ready_in,
      input  instr_out,
      input  pc_out,
      input  fetch_count,
      input  halted
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: pc register, IF/ID register with valid/ready handshake, redirect.
// Optional FETCH_HALT_ON_ZERO_EN: an all-zero fetched word halts fetch until a redirect.
module instruction_fetch #(
   parameter int address_length = 3
) (
   input logic                  clk,
   input logic                  reset,
   instruction_fetch_if.master  bus
);

   typedef enum logic {RUN, HALT} state_t;

   state_t                    state_q, state_d;
   logic [address_length-1:0] pc_p0;
   logic [address_length-1:0] pc_p1;
   logic [31:0]               instr_p1;
   logic                      vld_p1;
   logic [15:0]               fetch_cnt;
   logic                      transfer;
   logic                      load_slot;
   logic                      halt_on_zero;
   logic                      load;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      transfer     = vld_p1 & bus.ready_in;
      load_slot    = !bus.redirect_valid && (state_q == RUN) && (!vld_p1 || transfer);
`ifdef FETCH_HALT_ON_ZERO_EN
      halt_on_zero = load_slot && (bus.imem_data == 32'b0);
`else
      halt_on_zero = 1'b0;
`endif
      load         = load_slot && !halt_on_zero;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (halt_on_zero)       state_d = HALT;
         HALT:    if (bus.redirect_valid) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // p0 -> p1: pc feeds the memory, the IF/ID register captures its word
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_p0     <= '0;
         pc_p1     <= '0;
         instr_p1  <= '0;
         vld_p1    <= 1'b0;
         fetch_cnt <= '0;
      end else begin
         if (transfer) fetch_cnt <= sat_inc16(fetch_cnt);
         // A redirect flushes even when the current word is being handed off.
         if (bus.redirect_valid) begin
            pc_p0  <= bus.redirect_target;
            vld_p1 <= 1'b0;
         end else if (load) begin
            instr_p1 <= bus.imem_data;
            pc_p1    <= pc_p0;
            vld_p1   <= 1'b1;
            pc_p0    <= pc_p0 + address_length'(1);
         end else if (transfer) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign bus.imem_address = pc_p0;
   assign bus.valid_out    = vld_p1;
   assign bus.instr_out    = instr_p1;
   assign bus.pc_out       = pc_p1;
   assign bus.fetch_count  = fetch_cnt;
`ifdef FETCH_HALT_ON_ZERO_EN
   assign bus.halted       = (state_q == HALT);
`else
   assign bus.halted       = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 4-instruction program in an 8-word memory.
module tb_instruction_fetch;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   instruction_fetch_if #(.address_length(3)) ifc();

   instruction_fetch #(.address_length(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] prog(input logic [2:0] a);
      case (a)
         3'd0:    return 32'h2C00000A;
         3'd1:    return 32'h2C010001;
         3'd2:    return 32'h08210001;
         3'd3:    return 32'h18017FFF;
         default: return 32'h0;
      endcase
   endfunction

   assign ifc.imem_data = prog(ifc.imem_address);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      reset               = 1'b1;
      ifc.ready_in        = 1'b0;
      ifc.redirect_valid  = 1'b0;
      ifc.redirect_target = 3'd0;
      step();
      step();
      check("rst_valid", 32'(ifc.valid_out), 32'd0);
      check("rst_instr", ifc.instr_out, 32'd0);
      check("rst_pc_out", 32'(ifc.pc_out), 32'd0);
      check("rst_count", 32'(ifc.fetch_count), 32'd0);
      check("rst_halted", 32'(ifc.halted), 32'd0);

      // first fetch after reset release
      reset        = 1'b0;
      ifc.ready_in = 1'b1;
      check("first_addr", 32'(ifc.imem_address), 32'd0);
      step();
      check("first_valid", 32'(ifc.valid_out), 32'd1);
      check("first_instr", ifc.instr_out, 32'h2C00000A);
      check("first_pc_out", 32'(ifc.pc_out), 32'd0);
      check("first_addr2", 32'(ifc.imem_address), 32'd1);

      // stall three cycles
      ifc.ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_instr", ifc.instr_out, 32'h2C00000A);
         check("stall_pc_out", 32'(ifc.pc_out), 32'd0);
         check("stall_addr", 32'(ifc.imem_address), 32'd1);
         check("stall_count", 32'(ifc.fetch_count), 32'd0);
      end
      ifc.ready_in = 1'b1;
      step();
      check("release_instr", ifc.instr_out, 32'h2C010001);
      check("release_pc_out", 32'(ifc.pc_out), 32'd1);
      check("release_count", 32'(ifc.fetch_count), 32'd1);

      // redirect while stalled
      ifc.ready_in        = 1'b0;
      ifc.redirect_valid  = 1'b1;
      ifc.redirect_target = 3'd2;
      step();
      check("redir_valid", 32'(ifc.valid_out), 32'd0);
      check("redir_addr", 32'(ifc.imem_address), 32'd2);
      check("redir_count", 32'(ifc.fetch_count), 32'd1);
      ifc.redirect_valid = 1'b0;
      step();
      check("redir_instr", ifc.instr_out, 32'h08210001);
      check("redir_pc_out", 32'(ifc.pc_out), 32'd2);
      check("redir_valid2", 32'(ifc.valid_out), 32'd1);

      // redirect coinciding with a transfer: counted, then flushed
      ifc.ready_in        = 1'b1;
      ifc.redirect_valid  = 1'b1;
      ifc.redirect_target = 3'd0;
      step();
      check("rx_count", 32'(ifc.fetch_count), 32'd2);
      check("rx_valid", 32'(ifc.valid_out), 32'd0);
      check("rx_addr", 32'(ifc.imem_address), 32'd0);
      ifc.redirect_valid = 1'b0;
      step();
      check("rx_instr", ifc.instr_out, 32'h2C00000A);
      check("rx_pc_out", 32'(ifc.pc_out), 32'd0);

`ifdef FETCH_HALT_ON_ZERO_EN
      for (int k = 1; k <= 3; k++) step();
      check("h_pc_out", 32'(ifc.pc_out), 32'd3);
      check("h_instr", ifc.instr_out, 32'h18017FFF);
      step();
      check("h_halted", 32'(ifc.halted), 32'd1);
      check("h_addr", 32'(ifc.imem_address), 32'd4);
      check("h_valid", 32'(ifc.valid_out), 32'd0);
      step();
      check("h_hold_addr", 32'(ifc.imem_address), 32'd4);
      ifc.redirect_valid  = 1'b1;
      ifc.redirect_target = 3'd0;
      step();
      check("h_resume", 32'(ifc.halted), 32'd0);
      ifc.redirect_valid = 1'b0;
      step();
      check("h_restart", ifc.instr_out, 32'h2C00000A);
`else
      // free run through the zero words and the wrap
      for (int k = 1; k <= 8; k++) begin
         step();
         check("run_pc_out", 32'(ifc.pc_out), 32'(k % 8));
         check("run_instr", ifc.instr_out, prog(3'(k % 8)));
         check("run_count", 32'(ifc.fetch_count), 32'(2 + k));
         check("run_halted", 32'(ifc.halted), 32'd0);
      end
      check("run_wrap_addr", 32'(ifc.imem_address), 32'd1);
`endif

      // reset during a stall
      ifc.ready_in = 1'b0;
      step();
      reset = 1'b1;
      step();
      check("srst_valid", 32'(ifc.valid_out), 32'd0);
      check("srst_instr", ifc.instr_out, 32'd0);
      check("srst_pc_out", 32'(ifc.pc_out), 32'd0);
      check("srst_addr", 32'(ifc.imem_address), 32'd0);
      check("srst_count", 32'(ifc.fetch_count), 32'd0);
      check("srst_halted", 32'(ifc.halted), 32'd0);
      reset = 1'b0;

`ifndef FETCH_HALT_ON_ZERO_EN
      // saturation of the transfer counter
      ifc.ready_in = 1'b1;
      n = 0;
      while (ifc.fetch_count != 16'hFFFE && n < 70000) begin
         step();
         n++;
      end
      check("sat_reach", 32'(ifc.fetch_count), 32'h0000FFFE);
      for (int k = 0; k < 3; k++) step();
      check("sat_hold", 32'(ifc.fetch_count), 32'h0000FFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
